// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: operand mux select
// encodings, FSM state type and the stall down-counter width.
package fwd_hazard_unit_pkg;

  // Operand mux select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;  // value from register file
  localparam logic [1:0] FWD_EXMEM = 2'b10;  // bypass from EX/MEM result
  localparam logic [1:0] FWD_MEMWB = 2'b01;  // bypass from MEM/WB result

  // Hazard FSM states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // Wide enough for a load-use bubble of up to 4 cycles
  localparam int CNT_W = 3;

endpackage : fwd_hazard_unit_pkg

// File: rtl/fwd_hazard_unit_operand_sel.sv
// Per-operand forwarding select. Each operand is resolved on its own; the
// EX/MEM producer is younger than MEM/WB, so it wins when both match.
// Register 0 is hard-wired zero and is never bypassed.
module fwd_operand_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mem_wb_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  output logic [1:0]        sel
);

  logic exmem_hit;
  logic memwb_hit;

  // Compare this operand against both in-flight writers and pick the youngest
  always_comb begin
    exmem_hit = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs);
    memwb_hit = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs);
    sel       = FWD_RF;
    if (exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule : fwd_operand_sel

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for a classic 5-stage pipeline.
//  - fwd_sel: purely combinational bypass selects for the operands in EX.
//  - RUN/STALL/FLUSH FSM: load-use bubbles of LOAD_STALL_CYCLES cycles and
//    branch-redirect flushes; a taken branch overrides any stall.
// Optional feature: define FWD_STALL_CNT_EN to add the 32-bit saturating
// stall_count output (cycles of load-use bubble, flushes not counted).
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC           = 2,
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      mem_wb_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      ex_branch_taken,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      id_ex_bubble,
  output logic                      if_id_flush,
  output logic                      busy
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]               stall_count
`endif
);

  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [NUM_SRC-1:0] lu_hit;
  logic              load_use;
  logic              stall_bubble;

  // Forwarding selects and load-use compares, one slice per source operand
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_operand_sel #(
        .REG_AW (REG_AW)
      ) u_sel (
        .rs              (ex_rs[gi*REG_AW +: REG_AW]),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .sel             (fwd_sel[2*gi +: 2])
      );

      assign lu_hit[gi] = id_rs_used[gi] && (id_rs[gi*REG_AW +: REG_AW] == id_ex_rd);
    end
  endgenerate

  assign load_use = id_ex_memread && (id_ex_rd != '0) && (|lu_hit);

  // Next-state and same-cycle pipeline controls. During FLUSH the ID stage
  // holds the instruction squashed by the redirect, so load-use is ignored.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    stall_bubble = 1'b0;
    if (reset) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = ST_FLUSH;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (load_use) begin
            stall_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_STALL;
              cnt_d   = STALL_RELOAD;
            end
          end
        end
        ST_STALL: begin
          stall_bubble = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
      if (stall_bubble) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
    busy_d = (state_d != ST_RUN);
  end

  // FSM state, stall counter and registered busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Saturating count of load-use bubble cycles
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_bubble && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule : fwd_hazard_unit

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (NUM_SRC=2, REG_AW=5,
// LOAD_STALL_CYCLES=3). A cycle-level reference model tracks remaining
// bubble cycles and a pending-flush flag; forwarding is checked against the
// textual priority rule.
module tb_fwd_hazard_unit;

  localparam int NS  = 2;
  localparam int AW  = 5;
  localparam int LSC = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NS*AW-1:0]  ex_rs = '0;
  logic [NS*AW-1:0]  id_rs = '0;
  logic [NS-1:0]     id_rs_used = '0;
  logic              ex_mem_regwrite = 1'b0;
  logic [AW-1:0]     ex_mem_rd = '0;
  logic              mem_wb_regwrite = 1'b0;
  logic [AW-1:0]     mem_wb_rd = '0;
  logic              id_ex_memread = 1'b0;
  logic [AW-1:0]     id_ex_rd = '0;
  logic              ex_branch_taken = 1'b0;
  logic [2*NS-1:0]   fwd_sel;
  logic              pc_write, if_id_write, id_ex_bubble, if_id_flush, busy;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  fwd_hazard_unit #(
    .NUM_SRC           (NS),
    .REG_AW            (AW),
    .LOAD_STALL_CYCLES (LSC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_rs           (ex_rs),
    .id_rs           (id_rs),
    .id_rs_used      (id_rs_used),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .fwd_sel         (fwd_sel),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .busy            (busy)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  int          m_remaining = 0;   // bubble cycles still owed after this one
  bit          m_in_flush  = 1'b0;
  int unsigned m_count     = 0;
  int          obs_bubbles = 0;   // observed id_ex_bubble cycles (directed use)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
    if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_remaining = 0;
    m_in_flush  = 1'b0;
    m_count     = 0;
  endtask

  task automatic clear_inputs();
    ex_rs = '0; id_rs = '0; id_rs_used = '0;
    ex_mem_regwrite = 0; ex_mem_rd = '0;
    mem_wb_regwrite = 0; mem_wb_rd = '0;
    id_ex_memread = 0; id_ex_rd = '0; ex_branch_taken = 0;
  endtask

  // Called at posedge+1 with inputs applied: compare, advance model, next cycle
  task automatic step(input string tag);
    logic lu, stall;
    logic e_pc, e_ifid, e_bub, e_flush, e_busy;
    int   n_rem;
    bit   n_flush;
    lu = id_ex_memread && id_ex_rd != 0 &&
         ((id_rs_used[0] && id_rs[4:0] == id_ex_rd) ||
          (id_rs_used[1] && id_rs[9:5] == id_ex_rd));
    e_busy  = (m_remaining > 0) || m_in_flush;
    stall   = 1'b0;
    e_flush = 1'b0;
    e_bub   = 1'b0;
    n_rem   = m_remaining;
    n_flush = m_in_flush;
    if (ex_branch_taken) begin
      e_flush = 1'b1; e_bub = 1'b1; n_rem = 0; n_flush = 1'b1;
    end else if (m_in_flush) begin
      n_flush = 1'b0;
    end else if (m_remaining > 0) begin
      stall = 1'b1; n_rem = m_remaining - 1;
    end else if (lu) begin
      stall = 1'b1; n_rem = LSC - 1;
    end
    if (stall) e_bub = 1'b1;
    e_pc   = !stall;
    e_ifid = !stall;
    #1;
    chk({tag, ".fwd0"},  32'(fwd_sel[1:0]), 32'(exp_fwd(ex_rs[4:0])));
    chk({tag, ".fwd1"},  32'(fwd_sel[3:2]), 32'(exp_fwd(ex_rs[9:5])));
    chk({tag, ".pc"},    32'(pc_write),     32'(e_pc));
    chk({tag, ".ifid"},  32'(if_id_write),  32'(e_ifid));
    chk({tag, ".bub"},   32'(id_ex_bubble), 32'(e_bub));
    chk({tag, ".flush"}, 32'(if_id_flush),  32'(e_flush));
    chk({tag, ".busy"},  32'(busy),         32'(e_busy));
`ifdef FWD_STALL_CNT_EN
    chk({tag, ".cnt"},   stall_count,       m_count);
`endif
    obs_bubbles += int'(id_ex_bubble);
    if (stall) m_count++;
    m_remaining = n_rem;
    m_in_flush  = n_flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.pc",   32'(pc_write), 1);
    chk("rst.ifid", 32'(if_id_write), 1);
    chk("rst.bub",  32'(id_ex_bubble), 0);
    chk("rst.fl",   32'(if_id_flush), 0);
`ifdef FWD_STALL_CNT_EN
    chk("rst.cnt",  stall_count, 0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    // both operands x5, both writers x5: EX/MEM wins
    ex_rs = {5'd5, 5'd5}; ex_mem_regwrite = 1; ex_mem_rd = 5'd5;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd5;
    #1 chk("fwd_both_x5", 32'(fwd_sel), 32'b1010);
    step("fwd_both_x5");

    // operand0=x3 from MEM/WB, operand1=x7 from EX/MEM
    ex_rs = {5'd7, 5'd3}; ex_mem_rd = 5'd7; mem_wb_rd = 5'd3;
    #1 chk("fwd_split", 32'(fwd_sel), 32'b1001);
    step("fwd_split");

    // register 0 never forwarded
    ex_rs = '0; ex_mem_rd = '0; mem_wb_rd = '0;
    #1 chk("fwd_x0", 32'(fwd_sel), 32'b0000);
    step("fwd_x0");
    clear_inputs();

    // load-use on operand1: exactly LSC bubble cycles then RUN
    obs_bubbles = 0;
    id_ex_memread = 1; id_ex_rd = 5'd9; id_rs = {5'd9, 5'd1}; id_rs_used = 2'b10;
    step("lu_c1");
    clear_inputs();
    step("lu_c2");
    step("lu_c3");
    step("lu_run");
    chk("lu_len", 32'(obs_bubbles), 32'(LSC));
`ifdef FWD_STALL_CNT_EN
    chk("lu_cnt", stall_count, 32'd3);
`endif

    // branch in 2nd stall cycle cancels the stall
    id_ex_memread = 1; id_ex_rd = 5'd9; id_rs = {5'd9, 5'd1}; id_rs_used = 2'b10;
    step("br_c1");
    clear_inputs();
    ex_branch_taken = 1;
    step("br_c2");
    ex_branch_taken = 0;
    step("br_flush");
    step("br_run");

    // async reset in the middle of a stall
    id_ex_memread = 1; id_ex_rd = 5'd4; id_rs = {5'd2, 5'd4}; id_rs_used = 2'b01;
    step("ar_c1");
    #3 reset = 1'b1;
    #1;
    chk("ar.busy", 32'(busy), 0);
    chk("ar.pc",   32'(pc_write), 1);
    chk("ar.bub",  32'(id_ex_bubble), 0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    clear_inputs();
    step("ar_after");

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      ex_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used      = 2'($urandom_range(0, 3));
      ex_mem_regwrite = 1'($urandom_range(0, 1));
      ex_mem_rd       = 5'($urandom_range(0, 3));
      mem_wb_regwrite = 1'($urandom_range(0, 1));
      mem_wb_rd       = 5'($urandom_range(0, 3));
      id_ex_memread   = 1'($urandom_range(0, 1));
      id_ex_rd        = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_fwd_hazard_unit

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction (1..3).
REQ-002 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-003 SHALL have parameter LOAD_STALL_CYCLES, default 1, meaning load-use bubble length (1..4).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ex_rs  input  NUM_SRC*REG_AW  source addresses of the instruction in EX, operand i at [i*REG_AW +: REG_AW].
REQ-007 SHALL have port id_rs  input  NUM_SRC*REG_AW  source addresses of the instruction in ID.
REQ-008 SHALL have port id_rs_used  input  NUM_SRC  per-operand "source actually read" flag in ID.
REQ-009 SHALL have port ex_mem_regwrite  input  1, and port ex_mem_rd  input  REG_AW, giving the EX/MEM writer.
REQ-010 SHALL have port mem_wb_regwrite  input  1, and port mem_wb_rd  input  REG_AW, giving the MEM/WB writer.
REQ-011 SHALL have port id_ex_memread  input  1, and port id_ex_rd  input  REG_AW, giving the load currently in EX.
REQ-012 SHALL have port ex_branch_taken  input  1, meaning a redirect resolved in EX this cycle.
REQ-013 SHALL have port fwd_sel  output  2*NUM_SRC  per-operand mux select: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-014 SHALL have ports pc_write, if_id_write, id_ex_bubble, if_id_flush, each  output  1.
REQ-015 SHALL have port busy  output  1, high while the FSM is not in RUN.

Function
REQ-016 fwd_sel SHALL be combinational, and each operand SHALL be resolved independently (no cross-operand priority).
REQ-017 Operand i SHALL select 10 when ex_mem_regwrite, ex_mem_rd!=0 and ex_mem_rd==ex_rs[i]; otherwise 01 when the same conditions hold on the MEM/WB writer; otherwise 00.
REQ-018 Register 0 SHALL never be forwarded; when EX/MEM and MEM/WB both match, EX/MEM SHALL win.
REQ-019 Load-use hazard (LU) SHALL be: id_ex_memread & id_ex_rd!=0 & any i with id_rs_used[i] & id_rs[i]==id_ex_rd.
REQ-020 The FSM SHALL have three states: RUN, STALL, FLUSH.
REQ-021 In RUN with LU, the block SHALL assert the same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; if LOAD_STALL_CYCLES>1 it SHALL enter STALL with a down-counter loaded to LOAD_STALL_CYCLES-1.
REQ-022 In STALL, the stall outputs SHALL be held and the counter decremented each cycle; the FSM SHALL return to RUN when the counter reaches 1, so total bubble length is exactly LOAD_STALL_CYCLES.
REQ-023 ex_branch_taken SHALL take priority over LU in any state: same cycle if_id_flush=1, id_ex_bubble=1, pc_write=1; FSM to FLUSH for one cycle (busy=1, no flush outputs asserted), then RUN; any pending stall SHALL be cancelled.
REQ-024 Default outputs in RUN without hazard SHALL be pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
REQ-025 Forwarding SHALL remain valid in every FSM state.

Reset
REQ-026 reset SHALL asynchronously force state RUN, counter 0, busy=0, and stall_count 0 when present; combinational outputs SHALL then follow REQ-024.
REQ-027 Reset asserted mid-STALL SHALL abort the stall immediately.

Configuration
REQ-028 With FWD_STALL_CNT_EN defined, the block SHALL add port stall_count  output  32, a saturating count of cycles with id_ex_bubble=1 caused by LU or STALL (flushes excluded).
REQ-029 Without FWD_STALL_CNT_EN, stall_count and its register SHALL be absent, with all other behaviour identical.

Structure
REQ-030 The shared package SHALL hold the fwd_sel encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the FSM state typedef.
REQ-031 The per-operand compare logic SHALL be sub-module fwd_operand_sel, instantiated NUM_SRC times in a generate loop.

Verification
REQ-032 ex_rs={x5,x5}, ex_mem writes x5, mem_wb writes x5 -> fwd_sel={10,10}.
REQ-033 ex_rs={x3,x7}, ex_mem writes x7, mem_wb writes x3 -> fwd_sel operand0=01, operand1=10.
REQ-034 ex_mem_rd=0 with regwrite=1 and ex_rs={x0,x0} -> fwd_sel={00,00}.
REQ-035 LOAD_STALL_CYCLES=3, load to x9 in EX, id_rs[1]=x9 used -> id_ex_bubble=1 and pc_write=0 for exactly 3 cycles, then RUN; stall_count=3.
REQ-036 LOAD_STALL_CYCLES=3, ex_branch_taken in the 2nd stall cycle -> if_id_flush=1 that cycle, FLUSH for 1 cycle, then RUN, and pc_write=1 throughout.
REQ-037 reset pulsed during STALL -> busy=0 and pc_write=1 asynchronously, without waiting for a clock edge.
